// File: rtl/nand_seq_unit.sv
// Bit-serial logic unit: every result bit is built from repeated evaluations of one
// shared 1-bit NAND cell, with two round-robin arbitrated requesters.

module nand_cell (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

module nand_seq_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic             busy_o
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t             state_q;
    logic               last_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, data_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         step_q;
    logic               t_q, t0_q, t1_q;
    logic               rsp_valid_q, rsp_id_q, rsp_err_q, busy_q;

    logic               gnt_c, accept_c, last_step_c, idx_last_c;
    logic [1:0]         step_max_c;
    logic               x_c, y_c, nand_y_c, abit_c, bbit_c;
    logic [2:0]         sel_op_c;
    logic [WIDTH-1:0]   sel_a_c, sel_b_c;

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        gnt_c    = req1_valid_i && (!req0_valid_i || !last_q);
        sel_op_c = gnt_c ? req1_op_i : req0_op_i;
        sel_a_c  = gnt_c ? req1_a_i  : req0_a_i;
        sel_b_c  = gnt_c ? req1_b_i  : req0_b_i;
    end

    assign req0_ready_o = (state_q == S_IDLE) && req0_valid_i && !gnt_c;
    assign req1_ready_o = (state_q == S_IDLE) && req1_valid_i && gnt_c;
    assign accept_c     = req0_ready_o || req1_ready_o;

    // Operand routing into the shared NAND for the current op and step.
    always_comb begin
        abit_c     = a_q[idx_q];
        bbit_c     = b_q[idx_q];
        x_c        = abit_c;
        y_c        = bbit_c;
        step_max_c = 2'd0;
        case (op_q)
            OP_NOT: y_c = abit_c;
            OP_AND: begin
                step_max_c = 2'd1;
                if (step_q == 2'd1) begin
                    x_c = t_q;
                    y_c = t_q;
                end
            end
            OP_OR: begin
                step_max_c = 2'd2;
                case (step_q)
                    2'd0:    begin x_c = abit_c; y_c = abit_c; end
                    2'd1:    begin x_c = bbit_c; y_c = bbit_c; end
                    default: begin x_c = t0_q;   y_c = t1_q;   end
                endcase
            end
            OP_XOR: begin
                step_max_c = 2'd3;
                case (step_q)
                    2'd0:    begin x_c = abit_c; y_c = bbit_c; end
                    2'd1:    begin x_c = abit_c; y_c = t_q;    end
                    2'd2:    begin x_c = bbit_c; y_c = t_q;    end
                    default: begin x_c = t0_q;   y_c = t1_q;   end
                endcase
            end
            default: ;
        endcase
        last_step_c = (step_q == step_max_c);
        idx_last_c  = (idx_q == IDX_W'(WIDTH - 1));
    end

    nand_cell u_nand (
        .a_i (x_c),
        .b_i (y_c),
        .y_o (nand_y_c)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            step_q      <= 2'd0;
            t_q         <= 1'b0;
            t0_q        <= 1'b0;
            t1_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        op_q     <= sel_op_c;
                        a_q      <= sel_a_c;
                        b_q      <= sel_b_c;
                        rsp_id_q <= gnt_c;
                        last_q   <= gnt_c;
                        idx_q    <= '0;
                        step_q   <= 2'd0;
                        data_q   <= '0;
                        busy_q   <= 1'b1;
                        if (sel_op_c > OP_XOR) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            rsp_err_q <= 1'b0;
                            state_q   <= S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    if (last_step_c) begin
                        data_q[idx_q] <= nand_y_c;
                        step_q        <= 2'd0;
                        if (idx_last_c) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        step_q <= step_q + 2'd1;
                        // Intermediate steps park their result in a temporary.
                        case (op_q)
                            OP_AND: t_q <= nand_y_c;
                            OP_OR: begin
                                if (step_q == 2'd0) t0_q <= nand_y_c;
                                else                t1_q <= nand_y_c;
                            end
                            OP_XOR: begin
                                case (step_q)
                                    2'd0:    t_q  <= nand_y_c;
                                    2'd1:    t0_q <= nand_y_c;
                                    default: t1_q <= nand_y_c;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = data_q;
    assign busy_o      = busy_q;

endmodule
